// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the RAM arbiter slice.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    ACK     = 3'd4
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port RAM.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;
  logic [DATA_W-1:0] ram_do;
  logic              ram_en;
  logic              ram_we;
  logic              ram_re;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_do,
    output f_ack, d_ack, rdata, busy, ram_addr, ram_di, ram_en, ram_we, ram_re
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_do,
    input  f_ack, d_ack, rdata, busy, ram_addr, ram_di, ram_en, ram_we, ram_re
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// Fixed data-over-fetch priority by default; round-robin on ties with MEM_ARB_RR_EN.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  gnt_e last_gnt,
`endif
  input  logic f_req,
  input  logic d_req,
  output logic req_any,
  output gnt_e gnt
);

  // Winner select; a lone requester always wins
  always_comb begin
    req_any = f_req | d_req;
    gnt     = GNT_FETCH;
    if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      gnt = (last_gnt == GNT_DATA) ? GNT_FETCH : GNT_DATA;
`else
      gnt = GNT_DATA;
`endif
    end else if (d_req) begin
      gnt = GNT_DATA;
    end else begin
      gnt = GNT_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch/data ports onto a 1-cycle-read single-port RAM with registered strobes.
// Define MEM_ARB_RR_EN for round-robin tie breaking instead of fixed data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_e            state_r, next_state_s;
  gnt_e              gnt_r, gnt_s, pick_gnt_s;
  logic              req_any_s;

  logic              ram_en_r, ram_en_s;
  logic              ram_we_r, ram_we_s;
  logic              ram_re_r, ram_re_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0] ram_di_r, ram_di_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              f_ack_r, f_ack_s;
  logic              d_ack_r, d_ack_s;
  logic              busy_r, busy_s;

  // The held grant doubles as the last-grant memory for round-robin
  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_gnt (gnt_r),
`endif
    .f_req    (bus.f_req),
    .d_req    (bus.d_req),
    .req_any  (req_any_s),
    .gnt      (pick_gnt_s)
  );

  // State and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= GNT_FETCH;
    end else begin
      state_r <= next_state_s;
      gnt_r   <= gnt_s;
    end
  end

  // Next-state and grant latch
  always_comb begin
    next_state_s = state_r;
    gnt_s        = gnt_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          gnt_s        = pick_gnt_s;
          next_state_s = ((pick_gnt_s == GNT_DATA) && bus.d_we) ? WRITE : READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE:   next_state_s = ACK;
      READ:    next_state_s = CAPTURE;
      CAPTURE: next_state_s = ACK;
      ACK:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes only ever leave IDLE
  always_comb begin
    ram_en_s   = 1'b0;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    ram_addr_s = ram_addr_r;
    ram_di_s   = ram_di_r;
    rdata_s    = rdata_r;
    f_ack_s    = 1'b0;
    d_ack_s    = 1'b0;
    busy_s     = (next_state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          ram_en_s = 1'b1;
          if (pick_gnt_s == GNT_DATA) begin
            ram_addr_s = bus.d_addr;
            if (bus.d_we) begin
              ram_we_s = 1'b1;
              ram_di_s = bus.d_wdata;
            end else begin
              ram_re_s = 1'b1;
            end
          end else begin
            ram_addr_s = bus.f_addr;
            ram_re_s   = 1'b1;
          end
        end else begin
          ram_en_s = 1'b0;
        end
      end
      WRITE: begin
        f_ack_s = (gnt_r == GNT_FETCH);
        d_ack_s = (gnt_r == GNT_DATA);
      end
      CAPTURE: begin
        rdata_s = bus.ram_do;
        f_ack_s = (gnt_r == GNT_FETCH);
        d_ack_s = (gnt_r == GNT_DATA);
      end
      READ, ACK: begin
        f_ack_s = 1'b0;
        d_ack_s = 1'b0;
      end
      default: begin
        f_ack_s = 1'b0;
        d_ack_s = 1'b0;
      end
    endcase
  end

  // Output registers; async reset drops strobes before any pending write edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_r   <= 1'b0;
      ram_we_r   <= 1'b0;
      ram_re_r   <= 1'b0;
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_di_r   <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
      f_ack_r    <= 1'b0;
      d_ack_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      ram_en_r   <= ram_en_s;
      ram_we_r   <= ram_we_s;
      ram_re_r   <= ram_re_s;
      ram_addr_r <= ram_addr_s;
      ram_di_r   <= ram_di_s;
      rdata_r    <= rdata_s;
      f_ack_r    <= f_ack_s;
      d_ack_r    <= d_ack_s;
      busy_r     <= busy_s;
    end
  end

  assign bus.ram_en   = ram_en_r;
  assign bus.ram_we   = ram_we_r;
  assign bus.ram_re   = ram_re_r;
  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_di   = ram_di_r;
  assign bus.rdata    = rdata_r;
  assign bus.f_ack    = f_ack_r;
  assign bus.d_ack    = d_ack_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM (1-cycle registered read).
// Tie-order expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural RAM
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
    if (bus.ram_en && bus.ram_re) bus.ram_do <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = a; bus.d_wdata = v;
    tick();
    tick();
    check("setup_store_ack", bus.d_ack, 1);
    bus.d_req = 1'b0;
    tick();
  endtask

  logic          first_data;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] v1, v2;
  int            issued, acked;
  logic          fp, dp, prev_f, prev_d;

  initial begin
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst_n = 1'b0;
    #2;
    check("rst_ctrl", {bus.ram_en, bus.ram_we, bus.ram_re, bus.f_ack, bus.d_ack, bus.busy}, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_di", bus.ram_di, 0);
    check("rst_rdata", bus.rdata, 0);
    #10;
    rst_n = 1'b1;
    tick();

    // Store 0x1A3 to 0x005
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'h005; bus.d_wdata = 9'h1A3;
    tick();
    check("st_strobes_c1", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b110);
    check("st_addr_c1", bus.ram_addr, 11'h005);
    check("st_di_c1", bus.ram_di, 9'h1A3);
    check("st_busy_c1", bus.busy, 1);
    check("st_ack_c1", bus.d_ack, 0);
    tick();
    check("st_ack_c2", {bus.f_ack, bus.d_ack}, 2'b01);
    check("st_strobes_c2", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b000);
    bus.d_req = 1'b0;
    tick();
    check("st_busy_c3", bus.busy, 0);
    check("st_ack_c3", bus.d_ack, 0);

    // Load it back
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h005;
    tick();
    check("ld_strobes_c1", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b101);
    check("ld_addr_c1", bus.ram_addr, 11'h005);
    tick();
    check("ld_strobes_c2", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b000);
    check("ld_ack_c2", bus.d_ack, 0);
    tick();
    check("ld_ack_c3", {bus.f_ack, bus.d_ack}, 2'b01);
    check("ld_rdata_c3", bus.rdata, 9'h1A3);
    bus.d_req = 1'b0;
    tick();
    check("ld_ack_c4", bus.d_ack, 0);
    check("ld_rdata_hold", bus.rdata, 9'h1A3);
    check("ld_busy_c4", bus.busy, 0);

    store(11'h7FF, 9'h0AB);
    store(11'h010, 9'h155);

    // Simultaneous fetch 0x010 and data load 0x7FF; last grant was data
`ifdef MEM_ARB_RR_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif
    a1 = first_data ? 11'h7FF : 11'h010;  v1 = first_data ? 9'h0AB : 9'h155;
    a2 = first_data ? 11'h010 : 11'h7FF;  v2 = first_data ? 9'h155 : 9'h0AB;
    bus.f_req = 1'b1; bus.f_addr = 11'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h7FF;
    tick();
    check("tie_first_addr", bus.ram_addr, a1);
    check("tie_first_strobes", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b101);
    tick();
    check("tie_first_noack", {bus.f_ack, bus.d_ack}, 2'b00);
    tick();
    check("tie_first_ack", {bus.f_ack, bus.d_ack}, first_data ? 2'b01 : 2'b10);
    check("tie_first_rdata", bus.rdata, v1);
    if (first_data) bus.d_req = 1'b0; else bus.f_req = 1'b0;
    tick();
    check("tie_gap_ack", {bus.f_ack, bus.d_ack, bus.busy}, 3'b000);
    tick();
    check("tie_second_addr", bus.ram_addr, a2);
    tick();
    tick();
    check("tie_second_ack", {bus.f_ack, bus.d_ack}, first_data ? 2'b10 : 2'b01);
    check("tie_second_rdata", bus.rdata, v2);
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    tick();
    check("tie_done", {bus.f_ack, bus.d_ack, bus.busy}, 3'b000);

    // Random traffic in 0x100..0x1FF with invariant checks
    issued = 0; acked = 0; fp = 1'b0; dp = 1'b0; prev_f = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 2040; c++) begin
      tick();
      check("inv_we_re", bus.ram_we & bus.ram_re, 0);
      check("inv_en", bus.ram_en, bus.ram_we | bus.ram_re);
      check("inv_both_ack", bus.f_ack & bus.d_ack, 0);
      check("inv_pulse", (bus.f_ack & prev_f) | (bus.d_ack & prev_d), 0);
      prev_f = bus.f_ack; prev_d = bus.d_ack;
      if (bus.f_ack) begin acked++; fp = 1'b0; bus.f_req = 1'b0; end
      if (bus.d_ack) begin acked++; dp = 1'b0; bus.d_req = 1'b0; end
      if (c < 2000) begin
        if (!fp && $urandom_range(0, 2) == 0) begin
          fp = 1'b1; bus.f_req = 1'b1; issued++;
          bus.f_addr = 11'h100 + 11'($urandom_range(0, 255));
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1'b1; bus.d_req = 1'b1; issued++;
          bus.d_we = 1'($urandom_range(0, 1));
          bus.d_addr = 11'h100 + 11'($urandom_range(0, 255));
          bus.d_wdata = 9'($urandom_range(0, 511));
        end
      end
    end
    check("rand_drained", {fp, dp}, 2'b00);
    check("rand_ack_count", acked, issued);
    tick();

    // Reset in the WRITE cycle: the store must not land
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'h005; bus.d_wdata = 9'h0F0;
    tick();
    check("rw_strobes_pre", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_strobes_rst", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b000);
    check("rw_rdata_rst", bus.rdata, 0);
    check("rw_busy_rst", bus.busy, 0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    #10;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rw_no_ack", {bus.f_ack, bus.d_ack}, 2'b00);
    end
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h005;
    tick();
    tick();
    tick();
    check("rw_readback_ack", bus.d_ack, 1);
    check("rw_readback", bus.rdata, 9'h1A3);
    bus.d_req = 1'b0;
    tick();

    // Fetch withdrawn one cycle after grant still completes
    bus.f_req = 1'b1; bus.f_addr = 11'h7FF;
    tick();
    check("wd_strobes_c1", {bus.ram_en, bus.ram_we, bus.ram_re}, 3'b101);
    check("wd_addr_c1", bus.ram_addr, 11'h7FF);
    bus.f_req = 1'b0;
    tick();
    tick();
    check("wd_ack_c3", {bus.f_ack, bus.d_ack}, 2'b10);
    check("wd_rdata_c3", bus.rdata, 9'h0AB);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("wd_idle", {bus.busy, bus.ram_en, bus.f_ack, bus.d_ack}, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly upstream of the on-chip synchronous single-port RAM (11-bit address, 9-bit word, EN/WE/RE strobes, 1-cycle registered read).
- Arbitrates between the CPU instruction-fetch port (read-only) and the data port (load/store).
- Sequences each winning request into RAM strobes, never asserts WE and RE together, and returns read data with a one-cycle ack pulse.

Parameters:
- ADDR_W, 11, RAM address width.
- DATA_W, 9, RAM word width.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  ADDR_W  fetch address; stable while f_req pending
- f_ack  out  1  fetch complete, 1-cycle pulse; rdata valid
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while pending
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  data complete, 1-cycle pulse
- rdata  out  DATA_W  last read word; holds until next read capture
- busy  out  1  high in any state except IDLE
- ram_addr  out  ADDR_W  to RAM addr
- ram_di  out  DATA_W  to RAM DI
- ram_do  in  DATA_W  from RAM DO (valid only the cycle after a read strobe)
- ram_en  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE.
  - ram_en, ram_we, ram_re, f_ack, d_ack, busy = 0.
  - ram_addr, ram_di, rdata = 0.
  - Last-grant register = FETCH.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, WRITE, READ, CAPTURE, ACK.
- IDLE:
  - Sample f_req/d_req at each edge.
  - If either is set, pick a winner and latch the grant.
  - Register ram_addr (and ram_di = d_wdata for a store).
  - Assert ram_en plus exactly one of ram_we/ram_re.
  - Go to WRITE if the winner is data with d_we = 1, else READ.
  - No request: stay in IDLE, strobes low.
- WRITE: RAM writes at the closing edge; at that edge drop all strobes, go to ACK.
- READ: RAM latches DO at the closing edge; at that edge drop strobes, go to CAPTURE.
- CAPTURE: ram_do is valid; at the closing edge rdata <= ram_do, go to ACK.
- ACK:
  - The granted port's ack is high for exactly this cycle; the other ack stays 0.
  - Requests are ignored in ACK.
  - Next state is IDLE.
- Latency, counted from the IDLE edge that samples the request:
  - Store: ack high in cycle 2.
  - Load or fetch: ack high in cycle 3, with rdata valid from that cycle.
- Throughput: one transaction per 3 cycles (write) or 4 cycles (read).
- Requester rules:
  - The requester deasserts req at the edge ending its ack cycle.
  - A req held past that edge is treated as a new request.
- Default arbitration is fixed priority: data beats fetch on a simultaneous request.
- Request withdrawn mid-transaction: the transaction still completes and the ack still pulses. No abort.
- Invariant: ram_we && ram_re is never 1. ram_en is low whenever both strobes are low.
- rdata is not modified by writes.
- Reset mid-operation:
  - Strobes drop asynchronously, so a pending write is not performed unless its edge has already occurred.
  - rdata clears to 0; no ack is issued.
- Address wrap: none inside the block; the address is passed through unchanged.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a simultaneous f_req and d_req, the port not granted last wins.
  - The last-grant register updates on every grant; its reset value is FETCH, so the first tie goes to data.
  - A single requester always wins regardless of last grant.
- Undefined: fixed data-over-fetch priority; the last-grant register is not implemented.

Decomposition:
- Package mem_arb_pkg holds:
  - State enum (IDLE, WRITE, READ, CAPTURE, ACK).
  - Grant enum (GNT_FETCH, GNT_DATA).
  - Default constants ADDR_W_DEF = 11, DATA_W_DEF = 9.
- One sub-module, mem_arb_pick:
  - Combinational winner select from f_req, d_req and last-grant.
  - Includes the MEM_ARB_RR_EN logic.
- The top keeps the FSM and the registered RAM strobes.

Test Plan:
- Reset, then store: d_req = 1, d_we = 1, d_addr = 0x005, d_wdata = 0x1A3.
  - ram_en/ram_we high for 1 cycle with addr 0x005 and di 0x1A3.
  - d_ack high in cycle 2; busy low again in cycle 3.
- Load back: d_req = 1, d_we = 0, d_addr = 0x005.
  - ram_re high for 1 cycle.
  - d_ack in cycle 3 with rdata = 0x1A3; rdata holds 0x1A3 afterwards.
- Simultaneous f_req (addr 0x010) and d_req load (addr 0x7FF):
  - Default: data granted first, then fetch.
  - With MEM_ARB_RR_EN, after a prior data grant: fetch is granted first.
  - No cycle has both acks high.
- Strobe invariant: random f_req/d_req traffic for 2000 cycles.
  - Assert ram_we&&ram_re never true.
  - Each ack is a single-cycle pulse.
  - Ack count equals accepted request count.
- Reset during WRITE: assert rst_n = 0 mid-cycle after the IDLE grant edge.
  - All strobes 0 immediately; rdata = 0.
  - No d_ack; the target word is unchanged when read back after reset.
- Withdrawn request: drop f_req one cycle after grant.
  - f_ack still pulses in cycle 3; rdata updated.
  - Controller returns to IDLE and stays there.
